// File: rtl/consumatore_fifo_if.sv
// rtl/consumatore_fifo_if.sv - producer/pulse bundle for consumatore_fifo; abort exists only with ABORT_EN
interface consumatore_fifo_if #(
   parameter int W  = 8,
   parameter int AW = 2
) ();
   logic          eoc;
   logic [W-1:0]  numero;
   logic          soc;
   logic          out;
   logic [AW:0]   pending;
`ifdef ABORT_EN
   logic          abort;
`endif

   modport master (
      output eoc, numero,
`ifdef ABORT_EN
      output abort,
`endif
      input  soc, out, pending
   );

   modport slave (
      input  eoc, numero,
`ifdef ABORT_EN
      input  abort,
`endif
      output soc, out, pending
   );
endinterface

// File: rtl/consumatore_fifo.sv
// rtl/consumatore_fifo.sv - soc/eoc count acquisition into a FIFO, concurrent N-cycle pulse emission
// Optional feature ABORT_EN: synchronous abort of the pulse in progress.
module consumatore_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clock,
   input  logic              reset_,
   consumatore_fifo_if.slave bus
);
   localparam logic [1:0] A_REQ  = 2'd0;
   localparam logic [1:0] A_WAIT = 2'd1;
   localparam logic [1:0] A_HOLD = 2'd2;
   localparam logic [0:0] E_IDLE = 1'b0;
   localparam logic [0:0] E_RUN  = 1'b1;

   logic [1:0]    a_state;
   logic [0:0]    e_state;
   logic          soc_q;
   logic          out_q;
   logic [W-1:0]  cnt;
   logic [AW:0]   occ;
   logic [AW:0]   occ_next;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  head;
   logic          push;
   logic          pop;
   logic          room;
   logic          abort;

`ifdef ABORT_EN
   assign abort = bus.abort;
`else
   assign abort = 1'b0;
`endif

   assign head = mem[rd_ptr];
   assign push = (a_state == A_WAIT) && bus.eoc;
   // an abort seen while idle holds the head in the FIFO for one more cycle
   assign pop  = (e_state == E_IDLE) && (occ != '0) && !abort;

   always_comb begin
      occ_next = occ;
      if (push && !pop) occ_next = occ + (AW+1)'(1);
      if (pop && !push) occ_next = occ - (AW+1)'(1);
   end

   // room is judged on the occupancy after this edge so soc reopens as soon as a pop lands
   assign room = int'(occ_next) < DEPTH;

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         a_state <= A_REQ;
         soc_q   <= 1'b1;
      end else begin
         case (a_state)
            A_REQ: begin
               if (!bus.eoc) begin
                  soc_q   <= 1'b0;
                  a_state <= A_WAIT;
               end
            end
            A_WAIT: begin
               if (bus.eoc) begin
                  if (room) begin
                     soc_q   <= 1'b1;
                     a_state <= A_REQ;
                  end else begin
                     a_state <= A_HOLD;
                  end
               end
            end
            A_HOLD: begin
               if (room) begin
                  soc_q   <= 1'b1;
                  a_state <= A_REQ;
               end
            end
            default: begin
               soc_q   <= 1'b1;
               a_state <= A_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         occ <= occ_next;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= bus.numero;
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         e_state <= E_IDLE;
         out_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         case (e_state)
            E_IDLE: begin
               if (pop) begin
                  cnt <= head;
                  if (head != '0) begin
                     out_q   <= 1'b1;
                     e_state <= E_RUN;
                  end
               end
            end
            E_RUN: begin
               if (abort) begin
                  out_q   <= 1'b0;
                  cnt     <= '0;
                  e_state <= E_IDLE;
               end else begin
                  cnt <= cnt - W'(1);
                  if (cnt == W'(1)) begin
                     out_q   <= 1'b0;
                     e_state <= E_IDLE;
                  end
               end
            end
            default: begin
               out_q   <= 1'b0;
               e_state <= E_IDLE;
            end
         endcase
      end
   end

   assign bus.soc     = soc_q;
   assign bus.out     = out_q;
   assign bus.pending = occ;
endmodule

// File: tb/tb_consumatore_fifo.sv
// tb/tb_consumatore_fifo.sv - randomized and directed checks of consumatore_fifo against a queue-based model
module tb_consumatore_fifo;
   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int P_REQ  = 0;
   localparam int P_WAIT = 1;
   localparam int P_HOLD = 2;

   logic clock;
   logic reset_;
   consumatore_fifo_if #(.W(W), .AW(AW)) bus ();

   consumatore_fifo #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
      .clock  (clock),
      .reset_ (reset_),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   int q[$];
   int rem;
   int phase;
   bit m_soc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic model_reset();
      q.delete();
      rem   = 0;
      phase = P_REQ;
      m_soc = 1'b1;
   endtask

   // pulse = remaining high cycles; requester = request/wait/hold of the producer side
   task automatic model_edge(input bit e, input int n, input bit ab);
      bit was_wait;
      was_wait = (phase == P_WAIT);
      if (rem > 0) rem = ab ? 0 : rem - 1;
      else if (q.size() > 0 && !ab) rem = q.pop_front();
      if (was_wait && e) q.push_back(n);
      case (phase)
         P_REQ:  if (!e) phase = P_WAIT;
         P_WAIT: if (e) phase = (q.size() < DEPTH) ? P_REQ : P_HOLD;
         default: if (q.size() < DEPTH) phase = P_REQ;
      endcase
      m_soc = (phase == P_REQ);
   endtask

   task automatic step();
      bit ab;
      @(posedge clock);
      #1;
`ifdef ABORT_EN
      ab = bus.abort;
`else
      ab = 1'b0;
`endif
      if (!reset_) model_reset();
      else model_edge(bus.eoc, int'(bus.numero), ab);
      check("out", {31'd0, bus.out}, {31'd0, rem > 0});
      check("soc", {31'd0, bus.soc}, {31'd0, m_soc});
      check("pending", {29'd0, bus.pending}, q.size());
   endtask

   task automatic produce(input int n);
      int t;
      t = 0;
      while (bus.soc !== 1'b1 && t < 1000) begin
         step();
         t++;
      end
      check("soc_wait", {31'd0, bus.soc}, 32'd1);
      bus.eoc = 1'b0;
      step();
      bus.eoc    = 1'b1;
      bus.numero = W'(n);
      step();
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((bus.out !== 1'b0 || bus.pending !== '0) && t < 2000) begin
         step();
         t++;
      end
      check("idle_wait", {29'd0, bus.pending}, 32'd0);
   endtask

   task automatic do_reset();
      reset_  = 1'b0;
      bus.eoc = 1'b1;
      model_reset();
      step();
      step();
      reset_ = 1'b1;
   endtask

   initial begin
      bit exp_t1 [4];
      exp_t1[0] = 1'b1; exp_t1[1] = 1'b1; exp_t1[2] = 1'b1; exp_t1[3] = 1'b0;
      reset_     = 1'b0;
      bus.eoc    = 1'b1;
      bus.numero = '0;
`ifdef ABORT_EN
      bus.abort  = 1'b0;
`endif
      model_reset();
      #12;
      check("rst_soc", {31'd0, bus.soc}, 32'd1);
      check("rst_out", {31'd0, bus.out}, 32'd0);
      check("rst_pending", {29'd0, bus.pending}, 32'd0);
      do_reset();

      // count 3: rises on the edge after the push, high exactly three cycles
      produce(3);
      check("t1_lat0", {31'd0, bus.out}, 32'd0);
      check("t1_pend", {29'd0, bus.pending}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t1_pulse", {31'd0, bus.out}, {31'd0, exp_t1[i]});
      end

      // zero count is discarded without a pulse
      produce(0);
      step();
      check("t2_pend", {29'd0, bus.pending}, 32'd0);
      check("t2_out", {31'd0, bus.out}, 32'd0);
      wait_idle();

      // long pulse keeps emission busy while the FIFO fills
      produce(200);
      for (int i = 0; i < 4; i++) produce($urandom_range(1, 5));
      check("t3_full", {29'd0, bus.pending}, 32'd4);
      check("t3_hold", {31'd0, bus.soc}, 32'd0);
      produce(3);
      wait_idle();

      // back-to-back counts with one-cycle gap
      produce(6);
      produce(2);
      produce(1);
      wait_idle();

      // asynchronous reset in the middle of a pulse
      produce(10);
      for (int i = 0; i < 4; i++) step();
      check("t5_pre", {31'd0, bus.out}, 32'd1);
      #3;
      reset_  = 1'b0;
      bus.eoc = 1'b1;
      #1;
      check("t5_out", {31'd0, bus.out}, 32'd0);
      check("t5_soc", {31'd0, bus.soc}, 32'd1);
      check("t5_pend", {29'd0, bus.pending}, 32'd0);
      model_reset();
      step();
      reset_ = 1'b1;

`ifdef ABORT_EN
      produce(10);
      produce(5);
      while (rem > 7) step();
      bus.abort = 1'b1;
      step();
      check("t6_abort", {31'd0, bus.out}, 32'd0);
      bus.abort = 1'b0;
      wait_idle();
`endif

      // randomized handshake traffic
      for (int i = 0; i < 400; i++) begin
         bus.eoc    = $urandom_range(0, 1) == 1;
         bus.numero = W'($urandom_range(0, 7));
`ifdef ABORT_EN
         bus.abort  = $urandom_range(0, 15) == 0;
`endif
         if (i == 200) bus.numero = W'(255);
         step();
      end
      bus.eoc = 1'b1;
`ifdef ABORT_EN
      bus.abort = 1'b0;
`endif
      wait_idle();
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
